// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: AES-128 round-key generator for the inverse cipher.
// Expands the cipher key forward to the round-10 key, then steps backwards one
// round key per rd request (10, 9, ..., 0).
//
// Ports:
//   CLK     rising-edge clock
//   RST     asynchronous reset, active-high
//   load    pulse: start a new expansion from key_in (priority over rd)
//   key_in  cipher key, word 0 in [127:96]
//   rd      step to the previous round key (honoured only while valid)
//   rk      current round key (registered)
//   round   index of the key on rk, 0..10 (registered)
//   busy    forward expansion running (registered)
//   valid   rk usable and rd accepted (registered)
//
// Build option: define AES_FIXED_KEY_EN to ignore key_in and always expand the
// FIPS-197 test key 2b7e151628aed2a6abf7158809cf4f3c.

// Byte substitution table lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module aes_inv_key_schedule (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [127:0] key_in,
  input  logic         rd,
  output logic [127:0] rk,
  output logic [3:0]   round,
  output logic         busy,
  output logic         valid
);
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 4;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} state_e;

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   w_q, w_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  logic [KEY_W-1:0]   load_key_c;
  logic [WORD_W-1:0]  w3_inv_c, sbox_in_c, rot_c, t_c, rcon_c;
  logic [ROUND_W-1:0] rcon_idx_c;
  logic [KEY_W-1:0]   fwd_c, inv_c;

`ifdef AES_FIXED_KEY_EN
  logic unused_key_in_c;
  assign unused_key_in_c = ^key_in;
  assign load_key_c      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
  assign load_key_c      = key_in;
`endif

  // Round constant Rcon[idx] in the top byte; indices outside 0..9 never used.
  function automatic logic [WORD_W-1:0] rcon(input logic [ROUND_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h02;
      4'd2:    b = 8'h04;
      4'd3:    b = 8'h08;
      4'd4:    b = 8'h10;
      4'd5:    b = 8'h20;
      4'd6:    b = 8'h40;
      4'd7:    b = 8'h80;
      4'd8:    b = 8'h1b;
      4'd9:    b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h0};
  endfunction

  // Shared T() datapath: forward uses w3, inverse uses the recovered w3'.
  assign w3_inv_c   = w_q[31:0] ^ w_q[63:32];
  assign sbox_in_c  = (state_q == ST_READY) ? w3_inv_c : w_q[31:0];
  assign rot_c      = {sbox_in_c[23:0], sbox_in_c[31:24]};
  assign rcon_idx_c = (state_q == ST_READY) ? round_q - ROUND_W'(1) : round_q;
  assign rcon_c     = rcon(rcon_idx_c);

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_c[8*j +: 8]),
      .out_byte (t_c[8*j +: 8])
    );
  end

  // Forward step: round r -> r+1.
  always_comb begin
    fwd_c            = '0;
    fwd_c[127:96]    = w_q[127:96] ^ t_c ^ rcon_c;
    fwd_c[95:64]     = w_q[95:64] ^ fwd_c[127:96];
    fwd_c[63:32]     = w_q[63:32] ^ fwd_c[95:64];
    fwd_c[31:0]      = w_q[31:0]  ^ fwd_c[63:32];
  end

  // Inverse step: round r -> r-1.
  always_comb begin
    inv_c            = '0;
    inv_c[31:0]      = w3_inv_c;
    inv_c[63:32]     = w_q[63:32] ^ w_q[95:64];
    inv_c[95:64]     = w_q[95:64] ^ w_q[127:96];
    inv_c[127:96]    = w_q[127:96] ^ t_c ^ rcon_c;
  end

  // Next-state and output decode; load overrides everything.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    round_d = round_q;
    if (load) begin
      state_d = ST_EXPAND;
      w_d     = load_key_c;
      round_d = '0;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          w_d     = fwd_c;
          round_d = round_q + ROUND_W'(1);
          if (round_q == LAST_ROUND - ROUND_W'(1)) state_d = ST_READY;
        end
        ST_READY: begin
          if (rd && (round_q != '0)) begin
            w_d     = inv_c;
            round_d = round_q - ROUND_W'(1);
          end
        end
        default: ;
      endcase
    end
    busy_d  = (state_d == ST_EXPAND);
    valid_d = (state_d == ST_READY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign rk    = w_q;
  assign round = round_q;
  assign busy  = busy_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Testbench for aes_inv_key_schedule: reference key expansion computed from
// GF(2^8) arithmetic, randomized keys and rd patterns, known FIPS-197 vectors.
module tb_aes_inv_key_schedule;
  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         load = 1'b0;
  logic [127:0] key_in = '0;
  logic         rd = 1'b0;
  logic [127:0] rk;
  logic [3:0]   round;
  logic         busy;
  logic         valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] ref_rk [11];

  aes_inv_key_schedule dut (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .key_in (key_in),
    .rd     (rd),
    .rk     (rk),
    .round  (round),
    .busy   (busy),
    .valid  (valid)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gf_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] eff_key(input logic [127:0] k);
`ifdef AES_FIXED_KEY_EN
    return KEY_FIPS | (k & 128'h0);
`else
    return k;
`endif
  endfunction

  // Textbook word-by-word key expansion into ref_rk[0..10].
  task automatic build_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [127:0] key);
    load = 1'b1;
    key_in = key;
    tick();
    load = 1'b0;
    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({rk, round, busy, valid} !== 134'h0) begin
      n_err++;
      $display("FAIL reset_hold: got rk=%h round=%0d busy=%b valid=%b want all zero", rk, round, busy, valid);
    end
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      n_cmp++;
      if ({rk, round, busy, valid} !== 134'h0) begin
        n_err++;
        $display("FAIL idle_rd: got rk=%h round=%0d busy=%b valid=%b want all zero", rk, round, busy, valid);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_known_vector();
    logic [127:0] k;
`ifdef AES_FIXED_KEY_EN
    k = 128'h0;
`else
    k = KEY_FIPS;
`endif
    build_ref(eff_key(k));
    do_load(k);
    n_cmp++;
    if ({rk, round, busy, valid} !== {KEY_FIPS, 4'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL load_first: got rk=%h round=%0d busy=%b valid=%b want rk=%h round=0 busy=1 valid=0",
               rk, round, busy, valid, KEY_FIPS);
    end
    for (int k2 = 1; k2 <= 10; k2++) begin
      tick();
      n_cmp++;
      if ({rk, round, busy, valid} !== {ref_rk[k2], 4'(k2), 1'(k2 < 10), 1'(k2 == 10)}) begin
        n_err++;
        $display("FAIL expand_step%0d: got rk=%h round=%0d busy=%b valid=%b want rk=%h round=%0d",
                 k2, rk, round, busy, valid, ref_rk[k2], k2);
      end
    end
    n_cmp++;
    if (rk !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_err++;
      $display("FAIL fips_round10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk);
    end
    rd = 1'b1;
    for (int r = 9; r >= 0; r--) begin
      tick();
      n_cmp++;
      if ({rk, round, valid} !== {ref_rk[r], 4'(r), 1'b1}) begin
        n_err++;
        $display("FAIL stream_r%0d: got rk=%h round=%0d valid=%b want rk=%h", r, rk, round, valid, ref_rk[r]);
      end
      if (r == 9) begin
        n_cmp++;
        if (rk !== 128'hac7766f319fadc2128d12941575c006e) begin
          n_err++;
          $display("FAIL fips_round9: got %h want ac7766f319fadc2128d12941575c006e", rk);
        end
      end
      if (r == 1) begin
        n_cmp++;
        if (rk !== 128'ha0fafe1788542cb123a339392a6c7605) begin
          n_err++;
          $display("FAIL fips_round1: got %h want a0fafe1788542cb123a339392a6c7605", rk);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({rk, round, busy, valid} !== {KEY_FIPS, 4'd0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL hold_round0: got rk=%h round=%0d busy=%b valid=%b", rk, round, busy, valid);
      end
    end
    rd = 1'b0;
  endtask

  task automatic test_rd_during_expand();
    logic [127:0] k;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    build_ref(eff_key(k));
    do_load(k);
    rd = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++;
      if ({round, busy, valid} !== {4'(i), 1'(i < 10), 1'(i == 10)}) begin
        n_err++;
        $display("FAIL rd_expand_c%0d: got round=%0d busy=%b valid=%b want round=%0d", i, round, busy, valid, i);
      end
    end
    rd = 1'b0;
    n_cmp++;
    if (rk !== ref_rk[10]) begin
      n_err++;
      $display("FAIL rd_expand_rk: got %h want %h", rk, ref_rk[10]);
    end
    tick();
    n_cmp++;
    if ({rk, round, valid} !== {ref_rk[10], 4'd10, 1'b1}) begin
      n_err++;
      $display("FAIL rd_not_queued: got round=%0d rk=%h want round=10 rk=%h", round, rk, ref_rk[10]);
    end
  endtask

  task automatic test_load_during_ready();
    logic [127:0] k;
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    build_ref(eff_key(k));
    do_load(k);
    n_cmp++;
    if ({rk, round, busy, valid} !== {eff_key(k), 4'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reload: got rk=%h round=%0d busy=%b valid=%b want rk=%h round=0 busy=1 valid=0",
               rk, round, busy, valid, eff_key(k));
    end
    repeat (10) tick();
    n_cmp++;
    if ({rk, round, busy, valid} !== {ref_rk[10], 4'd10, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reload_done: got rk=%h round=%0d busy=%b valid=%b want rk=%h", rk, round, busy, valid, ref_rk[10]);
    end
  endtask

  task automatic test_reset_mid_expand();
    logic [127:0] k;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_load(k);
    repeat (4) tick();
    #1 RST = 1'b1;
    #1;
    n_cmp++;
    if ({rk, round, busy, valid} !== 134'h0) begin
      n_err++;
      $display("FAIL async_reset: got rk=%h round=%0d busy=%b valid=%b want all zero", rk, round, busy, valid);
    end
    tick();
    RST = 1'b0;
    tick();
    n_cmp++;
    if ({rk, round, busy, valid} !== 134'h0) begin
      n_err++;
      $display("FAIL no_resume: got rk=%h round=%0d busy=%b valid=%b want all zero", rk, round, busy, valid);
    end
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    build_ref(eff_key(k));
    do_load(k);
    repeat (9) tick();
    n_cmp++;
    if ({round, busy, valid} !== {4'd9, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_c9: got round=%0d busy=%b valid=%b want round=9 busy=1 valid=0", round, busy, valid);
    end
    tick();
    n_cmp++;
    if ({rk, round, busy, valid} !== {ref_rk[10], 4'd10, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset_done: got rk=%h round=%0d busy=%b valid=%b want rk=%h", rk, round, busy, valid, ref_rk[10]);
    end
  endtask

  task automatic test_random_stream();
    logic [127:0] k;
    int mr;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      build_ref(eff_key(k));
      do_load(k);
      repeat (10) tick();
      mr = 10;
      for (int c = 0; c < 24; c++) begin
        rd = 1'($urandom_range(0, 1));
        tick();
        if (rd && mr > 0) mr--;
        n_cmp++;
        if ({rk, round, busy, valid} !== {ref_rk[mr], 4'(mr), 1'b0, 1'b1}) begin
          n_err++;
          $display("FAIL rand_k%0d_c%0d: got rk=%h round=%0d valid=%b want rk=%h round=%0d",
                   n, c, rk, round, valid, ref_rk[mr], mr);
        end
      end
      rd = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_rd_during_expand();
    test_load_during_ready();
    test_reset_mid_expand();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
